ifu_fetch: RTL

- Instruction-fetch stage directly downstream of the branch-resolution unit.
- Holds the architectural fetch PC, which is fed back to the branch unit as its IFU PC.
- Issues one instruction-memory request at a time and presents the fetched instruction to the IF/ID pipe over a valid/ready handshake.
- Loads the branch unit's next-PC on every advance or redirect, and squashes in-flight or buffered fetches on redirect.

---
 rtl/ifu_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage holding the architectural fetch PC.
// Issues one imem request at a time and hands instructions to IF/ID.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_next_pc, i_redirect next PC and jump-taken flag from the branch unit
//   o_ifu_pc              current fetch PC, fed back to the branch unit
//   o_imem_req_*          request channel (valid/ready, address = o_ifu_pc)
//   i_imem_rsp_*          response channel (valid/ready, 32-bit word)
//   o_ifid_*              IF/ID channel (valid/ready, pc, inst, excp)
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a misaligned PC issues no request and is delivered as a
//               NOP_INST with o_ifid_excp=1
//   undefined : no alignment check, o_ifid_excp is always 0
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter logic [31:0]     NOP_INST = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_next_pc,
    input  logic            i_redirect,
    output logic [XLEN-1:0] o_ifu_pc,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_imem_rsp_ready,
    output logic            o_ifid_valid,
    input  logic            i_ifid_ready,
    output logic [XLEN-1:0] o_ifid_pc,
    output logic [31:0]     o_ifid_inst,
    output logic            o_ifid_excp
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] buf_pc;
    logic [31:0]     buf_inst;
    logic            excp;
    logic            misalign;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign = (pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            buf_pc   <= RESET_PC;
            buf_inst <= NOP_INST;
            excp     <= 1'b0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (i_redirect) begin
                        pc <= i_next_pc;
                        // A misaligned PC never issued a request, so
                        // nothing was accepted and nothing needs dropping.
                        if (i_imem_req_ready && !misalign)
                            state <= S_DROP;
                    end else if (misalign) begin
                        buf_inst <= NOP_INST;
                        buf_pc   <= pc;
                        excp     <= 1'b1;
                        state    <= S_HOLD;
                    end else if (i_imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        if (i_redirect) begin
                            pc    <= i_next_pc;
                            state <= S_REQ;
                        end else begin
                            buf_inst <= i_imem_rsp_data;
                            buf_pc   <= pc;
                            excp     <= 1'b0;
                            state    <= S_HOLD;
                        end
                    end else if (i_redirect) begin
                        // Response still owed: swallow it in DROP.
                        pc    <= i_next_pc;
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (i_ifid_ready || i_redirect) begin
                        pc    <= i_next_pc;
                        excp  <= 1'b0;
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (i_redirect)
                        pc <= i_next_pc;
                    if (i_imem_rsp_valid)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes, forced low while in reset.
    assign o_ifu_pc         = pc;
    assign o_imem_addr      = pc;
    assign o_imem_req_valid = !i_rst && (state == S_REQ) && !misalign;
    assign o_imem_rsp_ready = !i_rst &&
                              ((state == S_WAIT) || (state == S_DROP));
    assign o_ifid_valid     = !i_rst && (state == S_HOLD);
    assign o_ifid_pc        = buf_pc;
    assign o_ifid_inst      = buf_inst;
    assign o_ifid_excp      = excp;

endmodule
